// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate-generation stage: format codes and
// RV base opcodes (inst[6:2]).
package imm_gen_pkg;

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;
   localparam logic [2:0] FMT_NONE = 3'd7;

   localparam logic [4:0] OPC_LOAD      = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC_STORE     = 5'b01000;
   localparam logic [4:0] OPC_OP        = 5'b01100;
   localparam logic [4:0] OPC_LUI       = 5'b01101;
   localparam logic [4:0] OPC_OP_32     = 5'b01110;
   localparam logic [4:0] OPC_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC_JALR      = 5'b11001;
   localparam logic [4:0] OPC_JAL       = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle of the immediate-generation stage: input channel, flush
// and output channel. The stage uses the slave modport.
interface imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      inst_i;
   logic [TAG_W-1:0] tag_i;
   logic             flush_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  imm_o;
   logic [2:0]       fmt_o;
   logic             illegal_o;
   logic [31:0]      inst_o;
   logic [TAG_W-1:0] tag_o;

   modport slave (
      input  in_valid_i, inst_i, tag_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, inst_o, tag_o
   );

   modport master (
      output in_valid_i, inst_i, tag_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, inst_o, tag_o
   );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RV immediate decoder: inst -> {imm, fmt, illegal}.
// IMM_GEN_ZICSR_EN enables the CSR*I zero-extended uimm format.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      fmt_o,
   output logic            illegal_o
);

   logic [XLEN-1:0] sign_fill;
   assign sign_fill = {XLEN{inst_i[31]}};

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      imm_o     = '0;
      fmt_o     = FMT_NONE;
      illegal_o = 1'b1;
      if (inst_i[1:0] == 2'b11) begin
         illegal_o = 1'b0;
         unique case (inst_i[6:2])
            OPC_LUI, OPC_AUIPC: begin
               fmt_o       = FMT_U;
               imm_o       = sign_fill;
               imm_o[31:0] = {inst_i[31:12], 12'b0};
            end
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
               fmt_o       = FMT_I;
               imm_o       = sign_fill;
               imm_o[11:0] = inst_i[31:20];
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
               if (inst_i[14]) begin
                  fmt_o      = FMT_Z;
                  imm_o[4:0] = inst_i[19:15];
               end else begin
                  fmt_o       = FMT_I;
                  imm_o       = sign_fill;
                  imm_o[11:0] = inst_i[31:20];
               end
`else
               fmt_o       = FMT_I;
               imm_o       = sign_fill;
               imm_o[11:0] = inst_i[31:20];
`endif
            end
            OPC_OP_IMM_32: begin
               if (XLEN == 64) begin
                  fmt_o       = FMT_I;
                  imm_o       = sign_fill;
                  imm_o[11:0] = inst_i[31:20];
               end else begin
                  illegal_o = 1'b1;
               end
            end
            OPC_STORE: begin
               fmt_o       = FMT_S;
               imm_o       = sign_fill;
               imm_o[11:0] = {inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
               fmt_o       = FMT_B;
               imm_o       = sign_fill;
               imm_o[12:0] = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_JAL: begin
               fmt_o       = FMT_J;
               imm_o       = sign_fill;
               imm_o[20:0] = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            OPC_OP:    fmt_o = FMT_R;
            OPC_OP_32: begin
               if (XLEN == 64) fmt_o = FMT_R;
               else            illegal_o = 1'b1;
            end
            default:   illegal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry (output + skid) buffer
// and flush. Optional CSR*I decode via IMM_GEN_ZICSR_EN (see imm_decode).
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   imm_gen_stage_if.slave bus
);

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_ill;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst_i    (bus.inst_i),
      .imm_o     (dec_imm),
      .fmt_o     (dec_fmt),
      .illegal_o (dec_ill)
   );

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   logic [2:0]       out_fmt_q,   out_fmt_d;
   logic             out_ill_q,   out_ill_d;
   logic [31:0]      out_inst_q,  out_inst_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;

   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   logic [2:0]       skid_fmt_q,   skid_fmt_d;
   logic             skid_ill_q,   skid_ill_d;
   logic [31:0]      skid_inst_q,  skid_inst_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

   logic accept;
   logic load_out;

   assign bus.in_ready_o = ~skid_valid_q;
   assign accept         = bus.in_valid_i & ~skid_valid_q;
   assign load_out       = ~out_valid_q | bus.out_ready_i;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_fmt_d    = out_fmt_q;
      out_ill_d    = out_ill_q;
      out_inst_d   = out_inst_q;
      out_tag_d    = out_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_fmt_d   = skid_fmt_q;
      skid_ill_d   = skid_ill_q;
      skid_inst_d  = skid_inst_q;
      skid_tag_d   = skid_tag_q;
      if (bus.flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (load_out) begin
         // A full skid implies in_ready_o=0, so it never competes with accept.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_fmt_d    = skid_fmt_q;
            out_ill_d    = skid_ill_q;
            out_inst_d   = skid_inst_q;
            out_tag_d    = skid_tag_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_imm_d  = dec_imm;
               out_fmt_d  = dec_fmt;
               out_ill_d  = dec_ill;
               out_inst_d = bus.inst_i;
               out_tag_d  = bus.tag_i;
            end
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_fmt_d   = dec_fmt;
         skid_ill_d   = dec_ill;
         skid_inst_d  = bus.inst_i;
         skid_tag_d   = bus.tag_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_fmt_q    <= FMT_NONE;
         out_ill_q    <= 1'b0;
         out_inst_q   <= '0;
         out_tag_q    <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_fmt_q    <= out_fmt_d;
         out_ill_q    <= out_ill_d;
         out_inst_q   <= out_inst_d;
         out_tag_q    <= out_tag_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // NOTE: the skid payload is not reset; it is only observed while skid_valid_q is set.
   always_ff @(posedge clk) begin
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
      skid_inst_q <= skid_inst_d;
      skid_tag_q  <= skid_tag_d;
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.imm_o       = out_imm_q;
   assign bus.fmt_o       = out_fmt_q;
   assign bus.illegal_o   = out_ill_q;
   assign bus.inst_o      = out_inst_q;
   assign bus.tag_o       = out_tag_q;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, registered immediate-generation stage for the decode pipeline. It accepts a 32-bit RV instruction plus a sideband tag over a valid/ready handshake and emits the sign-extended XLEN-wide immediate, a format code, an illegal flag, and the original instruction and tag one cycle later. A 2-entry buffer (output register plus skid register) absorbs downstream stalls without combinational ready paths. A flush input discards in-flight entries on a pipeline redirect.

Parameters:
XLEN, 32, datapath width of imm_o; legal values are 32 or 64.
TAG_W, 32, width of the sideband tag (typically PC) carried with each instruction.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid_i  in  1  instruction offered
in_ready_o  out  1  stage can accept; registered
inst_i  in  32  instruction word
tag_i  in  TAG_W  sideband, passed through unchanged
flush_i  in  1  drop all buffered and offered entries
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream accepts
imm_o  out  XLEN  sign-extended immediate
fmt_o  out  3  format code (see package)
illegal_o  out  1  unsupported opcode or inst[1:0]!=2'b11
inst_o  out  32  instruction passthrough
tag_o  out  TAG_W  tag passthrough

Behaviour:
- Reset (sync, high): out_valid_o=0, skid empty, in_ready_o=1, imm_o=0, fmt_o=FMT_NONE, illegal_o=0, inst_o=0, tag_o=0.
- Transfer in when in_valid_i&in_ready_o; transfer out when out_valid_o&out_ready_i. Latency is 1 cycle from accept to out_valid_o when unstalled. Throughput is 1 per cycle.
- Output register loads when !out_valid_o or out_ready_i. Its source is the skid entry if the skid is valid, otherwise the input.
- If the input is accepted while the output is valid and not taken, the input goes to the skid register. The next cycle in_ready_o=0.
- in_ready_o = !skid_valid, registered. Order is strictly preserved.
- Immediate is decoded before registration. Sign bit is always inst[31], replicated to XLEN.
- Format is selected by inst[6:2]:
  - U (01101 LUI, 00101 AUIPC): {inst[31:12],12'b0}, sign-extended.
  - I (00000 LOAD, 00100 OP-IMM, 11001 JALR, 11100 SYSTEM; 00110 OP-IMM-32 only if XLEN=64): inst[31:20].
  - S (01000): {inst[31:25],inst[11:7]}.
  - B (11000): {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - J (11011): {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - R (01100; 01110 if XLEN=64): imm=0, fmt=FMT_R.
  - Anything else, or inst[1:0]!=2'b11: imm=0, fmt=FMT_NONE, illegal=1.
- Flush: the next cycle out_valid_o=0, skid cleared, in_ready_o=1. Any input offered in the flush cycle is dropped, even if in_ready_o was high. Flush wins over simultaneous accept and out_ready_i.
- Reset mid-stall: all entries are discarded, same as the reset values.
- Data outputs hold their value while out_valid_o=1 and out_ready_i=0.

Optional Feature:
Macro IMM_GEN_ZICSR_EN.
- Defined: SYSTEM opcode with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) yields fmt=FMT_Z and imm=zero-extended inst[19:15].
- Undefined: all SYSTEM instructions use the I rule.

Decomposition:
- Package imm_gen_pkg holds:
  - Format localparams: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6, FMT_NONE=7.
  - 5-bit opcode constants.
- Sub-module imm_decode: purely combinational inst->{imm,fmt,illegal}, parametrised by XLEN. The stage instantiates it once and holds the handshake/skid logic.

Test Plan:
- addi 0xFFF00093, out_ready=1 -> one cycle later imm=0xFFFFFFFF, fmt=I, illegal=0.
- lui 0x123450B7 -> imm=0x12345000, fmt=U; sw 0xFE21AC23 -> imm=0xFFFFFFF8, fmt=S.
- beq 0xFE000EE3 -> imm=0xFFFFFFFC, fmt=B; jal 0x008000EF -> imm=0x00000008, fmt=J; XLEN=64 addi -> imm=0xFFFFFFFFFFFFFFFF.
- Backpressure: out_ready=0 for 3 cycles while offering A,B,C back-to-back:
  - A is held in the output register and B in the skid.
  - in_ready=0 and C is held by the source.
  - After release, A,B,C are delivered in order on consecutive cycles with no loss or duplication.
- flush_i with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered word never appears.
- 0x00000013 with inst[1:0] changed to 00, and opcode 11111 -> illegal=1, imm=0, fmt=NONE. With IMM_GEN_ZICSR_EN, csrrwi 0x0F5FD073 -> fmt=Z, imm=0x1F.
